// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RV32 control sequencer.
package multicycle_pkg;

  localparam int unsigned TIMEOUT_DEF = 256;
  localparam int unsigned CNT_W_DEF   = 32;
  // Wide enough for TIMEOUT-1 at the maximum TIMEOUT of 65535.
  localparam int unsigned TMR_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Decode bits captured in DECODE; later states look only at these.
  typedef struct packed {
    logic reg_write;
    logic mem_valid;
    logic mem_write;
    logic is_csr;
    logic is_ecall;
    logic is_mret;
  } dec_lat_t;

  // States that wait on an external ready and are covered by the timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Clear/count/expire wait counter shared by the FETCH and MEM handshakes.
module wait_timer
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  logic [TMR_W-1:0] r_cnt;

  // Wait-cycle counter: cleared outside the wait states, counts while not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + TMR_W'(1);
    end
  end

  assign o_expire = (r_cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 sequencer: FETCH/DECODE/EXEC/[MEM]/WB with all write enables.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_ready,
  output logic             ir_en,
  input  logic             dec_reg_write,
  input  logic             dec_mem_valid,
  input  logic             dec_mem_write,
  input  logic             dec_is_csr,
  input  logic             dec_is_ecall,
  input  logic             dec_is_mret,
  input  logic             dec_is_ebreak,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_ready,
  output logic             pc_en,
  output logic             rf_wen,
  output logic             csr_wen,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  dec_lat_t         r_dec;
  logic [CNT_W-1:0] r_instret;
  logic             r_bus_err;

  logic w_wait;
  logic w_ready;
  logic w_expire;

  assign w_wait  = is_wait_state(r_state);
  assign w_ready = (r_state == S_FETCH) ? ifu_ready : lsu_ready;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (~w_wait),
    .i_count  (w_wait & ~w_ready),
    .o_expire (w_expire)
  );

  // Sequencer: state, decode latches, retired count and sticky bus error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dec     <= '0;
      r_instret <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (ifu_ready) begin
            r_state <= S_DECODE;
          end else if (w_expire) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end
        end
        S_DECODE: begin
          r_dec <= {dec_reg_write, dec_mem_valid, dec_mem_write,
                    dec_is_csr, dec_is_ecall, dec_is_mret};
          if (dec_is_ebreak) begin
            r_state   <= S_HALT;
            r_instret <= r_instret + CNT_W'(1);
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: r_state <= r_dec.mem_valid ? S_MEM : S_WB;
        S_MEM: begin
          if (lsu_ready) begin
            r_state <= S_WB;
          end else if (w_expire) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode from registers; only ir_en looks at a live input.
  // mret never opens the CSR gate (the decoder keeps it exclusive of csr/ecall).
  assign state_o = r_state;
  assign ifu_req = (r_state == S_FETCH);
  assign ir_en   = (r_state == S_FETCH) & ifu_ready;
  assign lsu_req = (r_state == S_MEM);
  assign lsu_wen = (r_state == S_MEM) & r_dec.mem_write;
  assign pc_en   = (r_state == S_WB);
  assign rf_wen  = (r_state == S_WB) & r_dec.reg_write & ~r_dec.mem_write;
  assign csr_wen = (r_state == S_WB) & (r_dec.is_csr | r_dec.is_ecall) & ~r_dec.is_mret;
  assign halted  = (r_state == S_HALT);
  assign bus_err = r_bus_err;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl against a per-instruction cycle model.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, ifu_ready, ir_en;
  logic          dec_reg_write, dec_mem_valid, dec_mem_write;
  logic          dec_is_csr, dec_is_ecall, dec_is_mret, dec_is_ebreak;
  logic          lsu_req, lsu_wen, lsu_ready;
  logic          pc_en, rf_wen, csr_wen, halted, bus_err;
  logic [2:0]    state_o;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ir_en(ir_en),
    .dec_reg_write(dec_reg_write), .dec_mem_valid(dec_mem_valid),
    .dec_mem_write(dec_mem_write), .dec_is_csr(dec_is_csr),
    .dec_is_ecall(dec_is_ecall), .dec_is_mret(dec_is_mret),
    .dec_is_ebreak(dec_is_ebreak),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ready(lsu_ready),
    .pc_en(pc_en), .rf_wen(rf_wen), .csr_wen(csr_wen),
    .halted(halted), .bus_err(bus_err), .state_o(state_o), .instret(instret)
  );

  typedef struct {
    bit rw, mv, mw, csr, ecall, mret, ebreak;
    int wf, wm;
    bit tmo_f, tmo_m;
  } instr_t;

  // One expected cycle: outputs, instret, and the stimulus to apply (2 = random).
  typedef struct {
    logic [11:0]   vec;
    logic [CW-1:0] ir;
    int            fr;
    int            lr;
    bit            dec;
    logic [6:0]    dbits;
    bit            rstm;
  } cyc_t;

  cyc_t          q[$];
  int            m_instret;
  bit            m_halted, m_berr;
  int            vectors = 0;
  int            miscompares = 0;
  logic [11:0]   obs_vec;
  logic [CW-1:0] obs_ir;

  function automatic void push(input logic [2:0] st, input bit ireq, input bit iren,
                               input bit lreq, input bit lwen, input bit pce,
                               input bit rfw, input bit csw, input int fr, input int lr,
                               input bit dec, input logic [6:0] db);
    cyc_t c;
    c.vec   = {st, ireq, iren, lreq, lwen, pce, rfw, csw, m_halted, m_berr};
    c.ir    = CW'(m_instret);
    c.fr    = fr;
    c.lr    = lr;
    c.dec   = dec;
    c.dbits = db;
    c.rstm  = 1'b0;
    q.push_back(c);
  endfunction

  function automatic void push_halt(input int n);
    for (int i = 0; i < n; i++) push(S_HALT, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 7'd0);
  endfunction

  // Reset marker: the runner pulses rst, then this entry is the IDLE cycle.
  function automatic void model_reset();
    m_instret = 0;
    m_halted  = 1'b0;
    m_berr    = 1'b0;
    push(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 7'd0);
    q[q.size()-1].rstm = 1'b1;
  endfunction

  function automatic instr_t mk(input bit rw, input bit mv, input bit mw, input bit csr,
                                input bit ecall, input bit mret, input bit ebreak,
                                input int wf, input int wm);
    instr_t t;
    t.rw = rw; t.mv = mv; t.mw = mw; t.csr = csr; t.ecall = ecall; t.mret = mret;
    t.ebreak = ebreak; t.wf = wf; t.wm = wm; t.tmo_f = 1'b0; t.tmo_m = 1'b0;
    return t;
  endfunction

  // Expected cycle sequence of one instruction, straight from the stage rules.
  function automatic void model_instr(input instr_t t);
    logic [6:0] db;
    db = {t.rw, t.mv, t.mw, t.csr, t.ecall, t.mret, t.ebreak};
    if (t.tmo_f) begin
      for (int i = 0; i < int'(TMO); i++) push(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, db);
      m_halted = 1'b1; m_berr = 1'b1; push_halt(3);
      return;
    end
    for (int i = 0; i < t.wf; i++) push(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, db);
    push(S_FETCH, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, db);
    push(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1, db);
    if (t.ebreak) begin
      m_instret = (m_instret + 1) % (1 << CW);
      m_halted  = 1'b1; push_halt(3);
      return;
    end
    push(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, db);
    if (t.mv) begin
      if (t.tmo_m) begin
        for (int i = 0; i < int'(TMO); i++) push(S_MEM, 0, 0, 1, t.mw, 0, 0, 0, 2, 0, 0, db);
        m_halted = 1'b1; m_berr = 1'b1; push_halt(3);
        return;
      end
      for (int i = 0; i < t.wm; i++) push(S_MEM, 0, 0, 1, t.mw, 0, 0, 0, 2, 0, 0, db);
      push(S_MEM, 0, 0, 1, t.mw, 0, 0, 0, 2, 1, 0, db);
    end
    push(S_WB, 0, 0, 0, 0, 1, t.rw & ~t.mw, t.csr | t.ecall, 2, 2, 0, db);
    m_instret = (m_instret + 1) % (1 << CW);
  endfunction

  // Drive one cycle's inputs at the falling edge, sample #1 later, advance.
  task automatic apply(input cyc_t c);
    if (c.rstm) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    ifu_ready = (c.fr == 2) ? 1'($urandom) : (c.fr != 0);
    lsu_ready = (c.lr == 2) ? 1'($urandom) : (c.lr != 0);
    {dec_reg_write, dec_mem_valid, dec_mem_write, dec_is_csr,
     dec_is_ecall, dec_is_mret, dec_is_ebreak} = c.dec ? c.dbits : 7'($urandom);
    #1;
    obs_vec = {state_o, ifu_req, ir_en, lsu_req, lsu_wen, pc_en, rf_wen, csr_wen,
               halted, bus_err};
    obs_ir  = instret;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifu_ready = 1'b1; lsu_ready = 1'b1;
      {dec_reg_write, dec_mem_valid, dec_mem_write, dec_is_csr,
       dec_is_ecall, dec_is_mret, dec_is_ebreak} = 7'($urandom);
      @(negedge clk); #1;
      obs_vec = {state_o, ifu_req, ir_en, lsu_req, lsu_wen, pc_en, rf_wen, csr_wen,
                 halted, bus_err};
      vectors++;
      if (obs_vec !== 12'h000) begin
        miscompares++;
        $display("FAIL reset outputs cyc%0d got %03h want 000", i, obs_vec);
      end
      vectors++;
      if (instret !== CW'(0)) begin
        miscompares++;
        $display("FAIL reset instret cyc%0d got %0d want 0", i, instret);
      end
    end
  endtask

  task automatic test_alu();
    cyc_t c;
    int   n = 0;
    model_reset();
    model_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));   // addi
    model_instr(mk(1, 0, 0, 1, 0, 0, 0, 1, 0));   // csrrw
    model_instr(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));   // ecall
    model_instr(mk(0, 0, 0, 0, 0, 1, 0, 2, 0));   // mret
    model_instr(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));   // csr with rd=x0
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL alu outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL alu instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  task automatic test_mem();
    cyc_t c;
    int   n = 0;
    model_reset();
    model_instr(mk(1, 1, 0, 0, 0, 0, 0, 0, 3));   // lw, 3 wait cycles
    model_instr(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));   // sw with reg_write set
    model_instr(mk(0, 1, 1, 0, 0, 0, 0, 2, 2));   // sw with waits both sides
    model_instr(mk(1, 1, 0, 0, 0, 0, 0, 1, 0));   // lw zero-wait memory
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL mem outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL mem instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    cyc_t   c;
    instr_t t;
    int     n = 0;
    model_reset();
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0); t.tmo_f = 1'b1; model_instr(t);
    model_reset();
    model_instr(mk(1, 0, 0, 0, 0, 0, 0, TMO - 1, 0));  // ready at the limit wins
    model_instr(mk(1, 1, 0, 0, 0, 0, 0, 0, TMO - 1));
    t = mk(0, 1, 1, 0, 0, 0, 0, 0, 0); t.tmo_m = 1'b1; model_instr(t);
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL timeout outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL timeout instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  task automatic test_ebreak();
    cyc_t c;
    int   n = 0;
    model_reset();
    model_instr(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL ebreak outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL ebreak instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_mem();
    cyc_t c;
    int   n = 0;
    int   mem_seen = 0;
    model_reset();
    model_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    model_instr(mk(0, 1, 1, 0, 0, 0, 0, 0, 3));
    while (q.size() > 0 && mem_seen < 2) begin
      c = q.pop_front(); apply(c);
      if (c.vec[11:9] == 3'(S_MEM)) mem_seen++;
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL midmem outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      n++;
    end
    q.delete();
    lsu_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    obs_vec = {state_o, ifu_req, ir_en, lsu_req, lsu_wen, pc_en, rf_wen, csr_wen,
               halted, bus_err};
    vectors++;
    if (obs_vec !== 12'h000) begin
      miscompares++;
      $display("FAIL midmem async_reset outputs got %03h want 000", obs_vec);
    end
    vectors++;
    if (instret !== CW'(0)) begin
      miscompares++;
      $display("FAIL midmem async_reset instret got %0d want 0", instret);
    end
    @(negedge clk);
    model_reset();
    model_instr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    n = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL restart outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL restart instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t   c;
    instr_t t;
    int     n = 0;
    int     k;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: t = mk(1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
        1: t = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        2: t = mk(1'($urandom), 1, 1, 0, 0, 0, 0, 0, 0);
        3: t = mk(1'($urandom), 0, 0, 1, 0, 0, 0, 0, 0);
        4: t = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        default: t = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
      endcase
      t.wf = $urandom_range(0, TMO - 1);
      t.wm = $urandom_range(0, TMO - 1);
      model_instr(t);
    end
    model_instr(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    while (q.size() > 0) begin
      c = q.pop_front(); apply(c);
      vectors++;
      if (obs_vec !== c.vec) begin
        miscompares++;
        $display("FAIL b2b outputs cyc%0d got %03h want %03h", n, obs_vec, c.vec);
      end
      vectors++;
      if (obs_ir !== c.ir) begin
        miscompares++;
        $display("FAIL b2b instret cyc%0d got %0d want %0d", n, obs_ir, c.ir);
      end
      n++;
    end
  endtask

  initial begin
    ifu_ready = 1'b0; lsu_ready = 1'b0;
    {dec_reg_write, dec_mem_valid, dec_mem_write, dec_is_csr,
     dec_is_ecall, dec_is_mret, dec_is_ebreak} = 7'd0;
    test_reset();
    test_alu();
    test_mem();
    test_timeout();
    test_ebreak();
    test_reset_mid_mem();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
